// File: rtl/led_display_package.sv
// Shared LED-panel types and constants.
// Row bundles, HUB75 pin bundle and shifter state codes.
package led_display_package;

    localparam int GL_NUM_COL_PIXELS = 64;
    localparam int GL_NUM_ROWS       = 32;
    localparam int GL_BCM_BITS       = 8;
    localparam int GL_ROW_ADDR_W     = $clog2(GL_NUM_ROWS / 2);
    localparam int GL_PLANE_W        = $clog2(GL_BCM_BITS);

    typedef logic [GL_NUM_COL_PIXELS-1:0] pxl_row_t;

    typedef struct packed {
        pxl_row_t red;
        pxl_row_t green;
        pxl_row_t blue;
    } rgb_row_t;

    // Same bit order as the driver's s_row_data bus.
    typedef struct packed {
        rgb_row_t top;
        rgb_row_t bot;
    } hub_row_t;

    typedef struct packed {
        logic r0;
        logic g0;
        logic b0;
        logic r1;
        logic g1;
        logic b1;
        logic clk;
        logic lat;
        logic oe_n;
    } hub_pins_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SHIFT = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_BLANK = 3'd3;
    localparam logic [2:0] ST_LATCH = 3'd4;

endpackage

// File: rtl/hub75_oe_timer.sv
// Bit-plane display timer; owns the active-low output enable.
// Counts down independently of the shifter so shifting overlaps display.
module hub75_oe_timer #(
    parameter int TMR_W = 11
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    input  logic             i_enable,
    input  logic             i_force_off,
    output logic             o_oe_n,
    output logic             o_expired,
    output logic             o_expiring
);

    logic [TMR_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - TMR_W'(1);
        end
    end

    assign o_expired  = (r_cnt == '0);
    // Count reaches zero on the coming edge.
    assign o_expiring = (r_cnt <= TMR_W'(1));
    assign o_oe_n     = o_expired | ~i_enable | i_force_off;

endmodule

// File: rtl/hub75_bcm_row_driver.sv
// HUB75 row driver with binary-coded-modulation bit-planes.
// Shifts plane k+1 while the timer displays plane k.
module hub75_bcm_row_driver
    import led_display_package::*;
#(
    parameter  int NUM_COLS       = 64,
    parameter  int NUM_ROWS       = 32,
    parameter  int BCM_BITS       = 8,
    parameter  int SCLK_DIV       = 2,
    parameter  int BASE_OE_CYCLES = 4,
    parameter  int BLANK_CYCLES   = 2,
    localparam int ROW_ADDR_W     = $clog2(NUM_ROWS / 2),
    localparam int PLANE_W        = $clog2(BCM_BITS)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [6*NUM_COLS-1:0] s_row_data,
    input  logic [ROW_ADDR_W-1:0] s_row_addr,
    input  logic [PLANE_W-1:0]    s_plane,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  enable,
    output logic                  hub_r0,
    output logic                  hub_g0,
    output logic                  hub_b0,
    output logic                  hub_r1,
    output logic                  hub_g1,
    output logic                  hub_b1,
    output logic                  hub_clk,
    output logic                  hub_lat,
    output logic                  hub_oe_n,
    output logic [ROW_ADDR_W-1:0] hub_addr,
    output logic                  busy
);

    localparam int TMR_W = $clog2(BASE_OE_CYCLES * (2 ** BCM_BITS) + 1);
    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int DIV_W = $clog2(SCLK_DIV + 1);
    localparam int BLK_W = $clog2(BLANK_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYCLES - 1);

    logic [2:0]                r_state;
    logic                      r_live;
    logic [5:0][NUM_COLS-1:0]  r_data;
    logic [ROW_ADDR_W-1:0]     r_row;
    logic [ROW_ADDR_W-1:0]     r_addr;
    logic [PLANE_W-1:0]        r_plane;
    logic [COL_W-1:0]          r_col;
    logic [DIV_W-1:0]          r_div;
    logic                      r_high;
    logic [BLK_W-1:0]          r_blk;

    logic                      w_ready;
    logic [PLANE_W-1:0]        w_plane;
    logic                      w_oe_n;
    logic                      w_expired;
    logic                      w_expiring;
    hub_pins_t                 w_pins;

    assign w_ready = r_live && (r_state == ST_IDLE);
    assign w_plane = ({1'b0, s_plane} >= (PLANE_W + 1)'(BCM_BITS))
                   ? PLANE_W'(BCM_BITS - 1) : s_plane;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_live  <= 1'b0;
            r_data  <= '0;
            r_row   <= '0;
            r_addr  <= '0;
            r_plane <= '0;
            r_col   <= '0;
            r_div   <= '0;
            r_high  <= 1'b0;
            r_blk   <= '0;
        end else begin
            r_live <= 1'b1;
            unique case (r_state)
                ST_IDLE: begin
                    if (s_valid && w_ready) begin
                        r_data  <= s_row_data;
                        r_row   <= s_row_addr;
                        r_plane <= w_plane;
                        r_col   <= COL_W'(NUM_COLS - 1);
                        r_div   <= '0;
                        r_high  <= 1'b0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (r_div != DIV_LAST) begin
                        r_div <= r_div + DIV_W'(1);
                    end else begin
                        r_div  <= '0;
                        r_high <= ~r_high;
                        if (r_high) begin
                            for (int i = 0; i < 6; i++) begin
                                r_data[i] <= r_data[i] << 1;
                            end
                            r_col <= r_col - COL_W'(1);
                            if (r_col == '0) begin
                                r_state <= w_expiring ? ST_BLANK : ST_WAIT;
                                if (w_expiring) begin
                                    r_addr <= r_row;
                                end
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_expiring) begin
                        r_addr  <= r_row;
                        r_state <= ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    if (r_blk == BLK_LAST) begin
                        r_blk   <= '0;
                        r_state <= ST_LATCH;
                    end else begin
                        r_blk <= r_blk + BLK_W'(1);
                    end
                end
                ST_LATCH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    hub75_oe_timer #(
        .TMR_W(TMR_W)
    ) u_oe_timer (
        .clk        (clk),
        .nrst       (nrst),
        .i_load     (r_state == ST_LATCH),
        .i_load_val (TMR_W'(BASE_OE_CYCLES) << r_plane),
        .i_enable   (enable),
        .i_force_off((r_state == ST_BLANK) || (r_state == ST_LATCH)),
        .o_oe_n     (w_oe_n),
        .o_expired  (w_expired),
        .o_expiring (w_expiring)
    );

    always_comb begin
        w_pins      = '0;
        w_pins.r0   = r_data[5][NUM_COLS-1];
        w_pins.g0   = r_data[4][NUM_COLS-1];
        w_pins.b0   = r_data[3][NUM_COLS-1];
        w_pins.r1   = r_data[2][NUM_COLS-1];
        w_pins.g1   = r_data[1][NUM_COLS-1];
        w_pins.b1   = r_data[0][NUM_COLS-1];
        w_pins.clk  = (r_state == ST_SHIFT) && r_high;
        w_pins.lat  = (r_state == ST_LATCH);
        w_pins.oe_n = w_oe_n;
    end

    assign hub_r0   = w_pins.r0;
    assign hub_g0   = w_pins.g0;
    assign hub_b0   = w_pins.b0;
    assign hub_r1   = w_pins.r1;
    assign hub_g1   = w_pins.g1;
    assign hub_b1   = w_pins.b1;
    assign hub_clk  = w_pins.clk;
    assign hub_lat  = w_pins.lat;
    assign hub_oe_n = w_pins.oe_n;
    assign hub_addr = r_addr;
    assign s_ready  = w_ready;
    assign busy     = (r_state != ST_IDLE) || !w_expired;

endmodule

// File: tb/tb_hub75_bcm_row_driver.sv
// Scoreboard bench for hub75_bcm_row_driver.
// Second small instance covers plane clamping.
module tb_hub75_bcm_row_driver;

    localparam int NC  = 64;
    localparam int NR  = 32;
    localparam int BB  = 8;
    localparam int SD  = 2;
    localparam int BO  = 4;
    localparam int BL  = 2;
    localparam int AW  = $clog2(NR / 2);
    localparam int PW  = $clog2(BB);
    localparam int NC2 = 4;
    localparam int BB2 = 6;
    localparam int PW2 = $clog2(BB2);

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    logic [6*NC-1:0] s_row_data = '0;
    logic [AW-1:0]   s_row_addr = '0;
    logic [PW-1:0]   s_plane    = '0;
    logic            s_valid    = 1'b0;
    logic            enable     = 1'b1;
    logic            s_ready;
    logic hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1;
    logic hub_clk, hub_lat, hub_oe_n, busy;
    logic [AW-1:0]   hub_addr;

    logic [6*NC2-1:0] d2_data  = '0;
    logic [AW-1:0]    d2_raddr = '0;
    logic [PW2-1:0]   d2_plane = '0;
    logic             d2_valid = 1'b0;
    logic             d2_ready;
    logic d2_r0, d2_g0, d2_b0, d2_r1, d2_g1, d2_b1;
    logic d2_clk, d2_lat, d2_oe_n, d2_busy;
    logic [AW-1:0]    d2_addr;

    always #5 clk = ~clk;

    hub75_bcm_row_driver #(
        .NUM_COLS(NC), .NUM_ROWS(NR), .BCM_BITS(BB),
        .SCLK_DIV(SD), .BASE_OE_CYCLES(BO), .BLANK_CYCLES(BL)
    ) dut (
        .clk(clk), .nrst(nrst),
        .s_row_data(s_row_data), .s_row_addr(s_row_addr),
        .s_plane(s_plane), .s_valid(s_valid), .s_ready(s_ready),
        .enable(enable),
        .hub_r0(hub_r0), .hub_g0(hub_g0), .hub_b0(hub_b0),
        .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
        .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe_n(hub_oe_n),
        .hub_addr(hub_addr), .busy(busy)
    );

    hub75_bcm_row_driver #(
        .NUM_COLS(NC2), .NUM_ROWS(NR), .BCM_BITS(BB2),
        .SCLK_DIV(SD), .BASE_OE_CYCLES(BO), .BLANK_CYCLES(BL)
    ) dut2 (
        .clk(clk), .nrst(nrst),
        .s_row_data(d2_data), .s_row_addr(d2_raddr),
        .s_plane(d2_plane), .s_valid(d2_valid), .s_ready(d2_ready),
        .enable(1'b1),
        .hub_r0(d2_r0), .hub_g0(d2_g0), .hub_b0(d2_b0),
        .hub_r1(d2_r1), .hub_g1(d2_g1), .hub_b1(d2_b1),
        .hub_clk(d2_clk), .hub_lat(d2_lat), .hub_oe_n(d2_oe_n),
        .hub_addr(d2_addr), .busy(d2_busy)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: plane p (clamped to the top plane) shows base * 2^p cycles.
    function automatic int oe_cycles(input int plane, input int bits,
                                     input int base);
        int p;
        p = (plane >= bits) ? bits - 1 : plane;
        return base * (1 << p);
    endfunction

    function automatic logic [6*NC-1:0] rand_plane();
        logic [6*NC-1:0] v;
        for (int i = 0; i < 6 * NC / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    typedef struct {
        logic [6*NC-1:0] data;
        logic [AW-1:0]   addr;
        int              oe_len;
    } exp_t;

    exp_t exp_q[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t cur;
    bit   have_cur    = 0;
    bit   prev_clk    = 0;
    bit   win_open    = 0;
    int   edge_cnt    = 0;
    int   total_edges = 0;
    int   win_start   = 0;
    int   win_end     = 0;
    int   exp_low     = 0;
    int   act_low     = 0;
    int   oe_bad      = 0;
    int   oe_high_run = 100;
    int   lat_cyc     = 0;
    int   lat_count   = 0;
    int   last_low    = 0;

    // Monitor: pops one expectation per shifted plane, checks pins.
    always @(negedge clk) begin
        int   c;
        logic exp_oe_n;
        if (!nrst) begin
            exp_q.delete();
            have_cur    = 0;
            prev_clk    = 0;
            win_open    = 0;
            edge_cnt    = 0;
            oe_high_run = 100;
        end else begin
            if (hub_clk && !prev_clk) begin
                total_edges++;
                if (edge_cnt == 0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_shift", 1, 0);
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1;
                    end
                end
                if (have_cur && edge_cnt < NC) begin
                    c = NC - 1 - edge_cnt;
                    check("column_bits",
                          int'({hub_r0, hub_g0, hub_b0,
                                hub_r1, hub_g1, hub_b1}),
                          int'({cur.data[5*NC+c], cur.data[4*NC+c],
                                cur.data[3*NC+c], cur.data[2*NC+c],
                                cur.data[NC+c], cur.data[c]}));
                end
                edge_cnt++;
            end
            prev_clk = hub_clk;
            if (hub_lat) begin
                check("lat_edges", edge_cnt, NC);
                check("lat_addr", int'(hub_addr),
                      have_cur ? int'(cur.addr) : -1);
                check("lat_oe_off", int'(hub_oe_n), 1);
                check("lat_guard", int'(oe_high_run >= BL), 1);
                lat_cyc   = cyc;
                lat_count++;
                win_open  = have_cur;
                win_start = cyc + 1;
                win_end   = cyc + 1 + (have_cur ? cur.oe_len : 0);
                exp_low   = 0;
                act_low   = 0;
                edge_cnt  = 0;
                have_cur  = 0;
            end
            exp_oe_n = !(win_open && cyc >= win_start &&
                         cyc < win_end && enable);
            if (!exp_oe_n) exp_low++;
            if (!hub_oe_n) act_low++;
            if (hub_oe_n != exp_oe_n) oe_bad++;
            oe_high_run = hub_oe_n ? oe_high_run + 1 : 0;
            if (win_open && cyc == win_end - 1) begin
                check("oe_low_cycles", act_low, exp_low);
                check("oe_pattern", oe_bad, 0);
                last_low = act_low;
                oe_bad   = 0;
                win_open = 0;
            end
        end
    end

    task automatic send(input logic [6*NC-1:0] d, input int addr,
                        input int plane, output int acc);
        int n;
        n = 0;
        while (!s_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            check("ready_timeout", 0, 1);
            acc = -1;
            return;
        end
        s_row_data = d;
        s_row_addr = AW'(addr);
        s_plane    = PW'(plane);
        s_valid    = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        exp_q.push_back('{data: d, addr: AW'(addr),
                          oe_len: oe_cycles(plane, BB, BO)});
        s_valid    = 1'b0;
        s_row_data = ~d;
        s_row_addr = ~s_row_addr;
        check("ready_drop", int'(s_ready), 0);
        check("first_col",
              int'({hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1,
                    hub_clk}),
              int'({d[6*NC-1], d[5*NC-1], d[4*NC-1],
                    d[3*NC-1], d[2*NC-1], d[NC-1], 1'b0}));
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((busy || exp_q.size() != 0 || win_open) && n < limit);
        check("idle_reached", int'(busy || win_open), 0);
    endtask

    task automatic wait_lat(input int target, input int limit);
        int n;
        n = 0;
        while (lat_count < target && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("lat_reached", int'(lat_count >= target), 1);
    endtask

    task automatic d2_run(input int plane, input int addr);
        int n;
        int low;
        logic [6*NC2-1:0] d;
        n = 0;
        while (!d2_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        d        = (6*NC2)'($urandom);
        d2_data  = d;
        d2_raddr = AW'(addr);
        d2_plane = PW2'(plane);
        d2_valid = 1'b1;
        @(posedge clk);
        #1;
        d2_valid = 1'b0;
        check("d2_first_col",
              int'({d2_r0, d2_g0, d2_b0, d2_r1, d2_g1, d2_b1, d2_clk}),
              int'({d[6*NC2-1], d[5*NC2-1], d[4*NC2-1],
                    d[3*NC2-1], d[2*NC2-1], d[NC2-1], 1'b0}));
        n = 0;
        while (!d2_lat && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("d2_lat_seen", int'(d2_lat), 1);
        check("d2_addr", int'(d2_addr), addr);
        low = 0;
        repeat (300) begin
            @(negedge clk);
            if (!d2_oe_n) low++;
        end
        check("d2_clamp_oe", low, oe_cycles(plane, BB2, BO));
        check("d2_idle", int'(d2_busy), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, l0, l1, n;
        logic [6*NC-1:0] d;

        #2;
        check("rst_ready", int'(s_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pins",
              int'({hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1,
                    hub_clk, hub_lat, hub_oe_n}), 1);
        check("rst_addr", int'(hub_addr), 0);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        check("ready_before_edge", int'(s_ready), 0);
        @(posedge clk);
        #1;
        check("ready_after_release", int'(s_ready), 1);
        check("oe_after_release", int'(hub_oe_n), 1);
        repeat (10) @(negedge clk);
        check("idle_no_hclk", total_edges, 0);

        d = '0;
        d[5*NC +: NC] = 64'h8000_0000_0000_0001;
        send(d, 5, 0, acc);
        wait_idle(2000);
        check("lat_latency", lat_cyc - acc, 2 * NC * SD + BL);
        check("oe_len_p0", last_low, BO);
        check("p0_edges", total_edges, NC);

        l0 = lat_count;
        send(rand_plane(), 3, 7, acc);
        wait_lat(l0 + 1, 2000);
        l1 = lat_cyc;
        send(rand_plane(), 9, 0, acc2);
        wait_lat(l0 + 2, 2000);
        check("b2b_overlap",
              int'(acc2 + 2 * NC * SD <= l1 + oe_cycles(7, BB, BO)), 1);
        check("b2b_lat_gap", lat_cyc - l1, oe_cycles(7, BB, BO) + 1 + BL);
        wait_idle(2000);

        l0 = lat_count;
        send(rand_plane(), 12, 7, acc);
        wait_lat(l0 + 1, 2000);
        l1 = lat_cyc;
        repeat (50) @(posedge clk);
        #1 enable = 1'b0;
        repeat (100) @(posedge clk);
        #1 enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (busy && n < 2000);
        check("en_low_total", last_low, 412);
        check("en_expiry", cyc - l1, oe_cycles(7, BB, BO) + 1);

        for (int k = 0; k < 8; k++) begin
            enable = ($urandom_range(0, 3) != 0);
            send(rand_plane(), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 4)), acc);
        end
        wait_idle(3000);
        enable = 1'b1;

        d2_run(7, 4);
        d2_run(6, 9);
        d2_run(3, 15);

        send(rand_plane(), 7, 1, acc);
        n = 0;
        while (edge_cnt < 30 && n < 400) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("reach_edge30", edge_cnt, 30);
        nrst = 1'b0;
        #1;
        check("mid_rst_ready", int'(s_ready), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_pins",
              int'({hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1,
                    hub_clk, hub_lat, hub_oe_n}), 1);
        check("mid_rst_addr", int'(hub_addr), 0);
        repeat (3) @(negedge clk);
        #1 nrst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", int'(s_ready), 1);
        l0 = lat_count;
        n  = total_edges;
        send(rand_plane(), 2, 0, acc);
        wait_idle(2000);
        check("post_rst_lat", lat_count, l0 + 1);
        check("post_rst_edges", total_edges - n, NC);
        check("final_oe_pattern", oe_bad, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
